command_sequencer: RTL
======================

// Module: command_sequencer
// PURPOSE
//  Upstream stage of the datapath controller: accepts operator commands over a valid/ready handshake.
//  Drives the registered 4-bit command bus that the controller decodes into ULA/X/Y/Z controls.
//  Single-cycle ops are issued once. MULT/DIV are issued once per shift, count_in times back-to-back.
//  Every completed op ends with one DISP cycle so the Z register shows the result.
// PARAMETERS
//  COUNT_W   3        width of count_in and of the repeat counter (max 2^COUNT_W-1 shifts)
//  IDLE_CMD  4'b1001  opcode driven while idle. DISP: X/Y hold, Z reloads.
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset, asynchronous, active-high
//  cmd_in     in   4        requested opcode: CLR=0000 CLRLD=0001 LOADX=0010 ADD=0011 SUB=0100
//                           MULT=0101 DIV=0110 MIN=0111 MAX=1000 DISP=1001
//  count_in   in   COUNT_W  shift count, sampled with MULT/DIV only
//  cmd_valid  in   1        cmd_in/count_in valid
//  cmd_ready  out  1        high only in IDLE; transfer when cmd_valid && cmd_ready
//  cmd_out    out  4        registered command to the controller
//  busy       out  1        high in EXEC/REPEAT/SHOW
//  done       out  1        one-cycle pulse during the SHOW cycle
//  err        out  1        illegal-opcode indication (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, cmd_out=IDLE_CMD, count=0, busy=0, done=0, err=0.
//  All outputs are registered; cmd_ready/busy are decoded from the state register.
//  IDLE: cmd_out=IDLE_CMD, cmd_ready=1. On transfer at edge k:
//   - legal non-MULT/DIV op -> EXEC; cmd_out=op during cycle k+1.
//   - MULT/DIV, count_in=N>0 -> REPEAT; count loads N; cmd_out=op for exactly N cycles.
//   - MULT/DIV, count_in=0 -> SHOW directly; the op is never driven.
//   - opcode 1010..1111 -> stays IDLE; err pulses for 1 cycle; cmd_out unchanged.
//  EXEC -> SHOW after 1 cycle.
//  REPEAT: count decrements each cycle; after the cycle with count==1 -> SHOW.
//   No wrap: count never goes below 0.
//  SHOW: cmd_out=4'b1001 (DISP), done=1 -> IDLE next edge.
//  Latency: transfer to first op cycle = 1 clk. Op to done = 1 clk after the last op cycle.
//  cmd_valid while busy is ignored: no ready, no capture. The source must hold it.
//  Accepted DISP runs EXEC(DISP) then SHOW(DISP): two DISP cycles, done on the second.
//  rst during REPEAT aborts immediately: no further op cycles and no done pulse.
// CONFIGURATION
//  STICKY_ERR_EN defined:
//   - err is set on an illegal opcode and held until a CLR (0000) is transferred;
//     it clears on the edge that accepts CLR.
//   - While err=1, cmd_ready stays 1 but every non-CLR transfer is discarded
//     (no state change, cmd_out unchanged).
//  STICKY_ERR_EN undefined: err is a one-cycle pulse only; subsequent commands execute normally.
// STRUCTURE
//  Shared header cmd_defs.vh:
//   - opcode localparams CLR..DISP;
//   - state encodings IDLE=2'd0 EXEC=2'd1 REPEAT=2'd2 SHOW=2'd3;
//   - legality function/macro for 4-bit opcodes.
//  The controller includes the same header so opcodes are defined once.
//  Sub-module shift_counter: COUNT_W down-counter with load, dec, async reset, and zero/one flags;
//  instantiated once for REPEAT.
//  Top holds the FSM, the cmd_out register and the err logic.
// TESTING
//  1 Reset: assert rst asynchronously mid-cycle.
//    -> immediately cmd_out=1001, busy=0, cmd_ready=1, done=0, err=0.
//  2 ADD (0011) transfer at edge k.
//    -> k+1: cmd_out=0011, busy=1, ready=0.
//    -> k+2: cmd_out=1001, done=1.
//    -> k+3: ready=1, done=0.
//  3 MULT (0101), count_in=3.
//    -> cmd_out=0101 for exactly 3 consecutive cycles, then one DISP cycle with done=1, then IDLE.
//  4 DIV (0110), count_in=0.
//    -> 0110 never appears on cmd_out; next cycle cmd_out=1001 with done=1.
//  5 Illegal opcode 1100, then ADD, then CLR.
//    Without macro: err=1 for 1 cycle; ADD then executes normally.
//    With STICKY_ERR_EN: err stays 1; ADD is discarded (cmd_out stays 1001);
//                        CLR clears err and executes.
//  6 MULT with count 5; assert rst after the 2nd 0101 cycle.
//    -> cmd_out=1001 at once; no 0101 and no done after rst is released.

Source files
------------

// File: rtl/command_sequencer_pkg.sv
// Shared opcode, state and legality definitions for the command sequencer and its controller.
package command_sequencer_pkg;

  localparam logic [3:0] OP_CLR   = 4'b0000;
  localparam logic [3:0] OP_CLRLD = 4'b0001;
  localparam logic [3:0] OP_LOADX = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_MULT  = 4'b0101;
  localparam logic [3:0] OP_DIV   = 4'b0110;
  localparam logic [3:0] OP_MIN   = 4'b0111;
  localparam logic [3:0] OP_MAX   = 4'b1000;
  localparam logic [3:0] OP_DISP  = 4'b1001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    REPEAT = 2'd2,
    SHOW   = 2'd3
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_DISP);
  endfunction

  // MULT/DIV are the only ops issued once per shift
  function automatic logic op_is_shift(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/command_sequencer_shift_counter.sv
// Down-counter that paces the repeated MULT/DIV shift cycles; never wraps below zero.
module shift_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         one
);

  localparam logic [W-1:0] CNT_ONE = W'(1);

  // load has priority over decrement; decrement saturates at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - CNT_ONE;
    end else begin
      count <= count;
    end
  end

  assign zero = (count == '0);
  assign one  = (count == CNT_ONE);

endmodule

// File: rtl/command_sequencer.sv
// Command sequencer: valid/ready command intake driving the registered controller opcode bus.
// Optional feature macro: STICKY_ERR_EN (err held until a CLR is accepted).
module command_sequencer
  import command_sequencer_pkg::*;
#(
  parameter int         COUNT_W  = 3,
  parameter logic [3:0] IDLE_CMD = 4'b1001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         cmd_in,
  input  logic [COUNT_W-1:0] count_in,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic [3:0]         cmd_out,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t             state;
  logic               xfer;
  logic               accept;
  logic               illegal;
  logic               cnt_load;
  logic               cnt_dec;
  logic [COUNT_W-1:0] count;
  logic               cnt_zero;
  logic               cnt_one;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign xfer      = cmd_valid && cmd_ready;
  assign illegal   = xfer && !op_legal(cmd_in);

`ifdef STICKY_ERR_EN
  // while an error is latched only CLR gets through
  assign accept = xfer && op_legal(cmd_in) && (!err || (cmd_in == OP_CLR));
`else
  assign accept = xfer && op_legal(cmd_in);
`endif

  // counter control: load on a MULT/DIV with a non-zero count, count down while repeating
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (accept && op_is_shift(cmd_in) && (count_in != '0)) begin
      cnt_load = 1'b1;
    end else begin
      cnt_load = 1'b0;
    end
    if (state == REPEAT) begin
      cnt_dec = 1'b1;
    end else begin
      cnt_dec = 1'b0;
    end
  end

  shift_counter #(
    .W (COUNT_W)
  ) u_shift_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (count_in),
    .count    (count),
    .zero     (cnt_zero),
    .one      (cnt_one)
  );

  // sequencing FSM with registered command bus and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cmd_out <= IDLE_CMD;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && op_is_shift(cmd_in) && (count_in == '0)) begin
            state   <= SHOW;
            cmd_out <= OP_DISP;
            done    <= 1'b1;
          end else if (accept && op_is_shift(cmd_in)) begin
            state   <= REPEAT;
            cmd_out <= cmd_in;
          end else if (accept) begin
            state   <= EXEC;
            cmd_out <= cmd_in;
          end else begin
            state   <= IDLE;
            cmd_out <= IDLE_CMD;
          end
        end
        EXEC: begin
          state   <= SHOW;
          cmd_out <= OP_DISP;
          done    <= 1'b1;
        end
        REPEAT: begin
          // zero is unreachable here but still forces an exit rather than stalling
          if (cnt_one || cnt_zero) begin
            state   <= SHOW;
            cmd_out <= OP_DISP;
            done    <= 1'b1;
          end else begin
            state   <= REPEAT;
            cmd_out <= cmd_out;
          end
        end
        SHOW: begin
          state   <= IDLE;
          cmd_out <= IDLE_CMD;
        end
        default: begin
          state   <= IDLE;
          cmd_out <= IDLE_CMD;
        end
      endcase
    end
  end

  // illegal-opcode indication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
`ifdef STICKY_ERR_EN
    end else if (illegal) begin
      err <= 1'b1;
    end else if (accept && (cmd_in == OP_CLR)) begin
      err <= 1'b0;
    end else begin
      err <= err;
    end
`else
    end else begin
      err <= illegal;
    end
`endif
  end

endmodule
